alu_mul_seq: RTL and testbench

- Sequences the shared 16-bit ALU to perform an unsigned 16x16->32 multiply.
- Uses shift-add: the ALU does every add (ALU_F_ADD) and every hi-word shift (shift-right, fsel=1); the block holds only the product registers, carry, counter and FSM.
- Sits between the control unit (start/busy/done handshake) and the ALU control/operand ports; when idle it drives the ALU with neutral values.

---
 rtl/alu_mul_seq.sv | 135 +++++++++++++
 tb/tb_alu_mul_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// It drives a shared external ALU for every add and every hi-word shift.
// The block itself holds only the product registers, carry, counter and FSM.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               request, accepted only in IDLE or DONE
//   mcand, mplier       operands, captured when start is accepted
//   busy                high while the multiply is running (ADD/SHIFT)
//   done                one-cycle pulse when the product is ready
//   result, zero        {hi,lo} product and result==0; held until the next start
//   alu_a/b/f/fsel/csel/ucin   ALU operand and control drive
//   alu_y, alu_cout     combinational ALU result and carry out
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [4:0]           alu_f,
  output logic                 alu_fsel,
  output logic                 alu_csel,
  output logic                 alu_ucin,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_cout
);

  localparam logic [4:0] ALU_F_ADD = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_f    = '0;
    alu_fsel = 1'b0;
    alu_csel = 1'b0;
    alu_ucin = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          hi_d    = '0;
          lo_d    = mplier;
          mc_d    = mcand;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = mplier[0] ? S_ADD : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        alu_a   = hi_q;
        alu_b   = mc_q;
        alu_f   = ALU_F_ADD;
        hi_d    = alu_y;
        carry_d = alu_cout;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        alu_a    = hi_q;
        alu_b    = WIDTH'(1);
        alu_fsel = 1'b1;
        // The ALU shifts a zero into the MSB; replace it with the add's carry.
        hi_d            = alu_y;
        hi_d[WIDTH-1]   = carry_q;
        lo_d    = {hi_q[0], lo_q[WIDTH-1:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          // lo_q[1] is the multiplier bit that lands in lo[0] after this shift.
          state_d = lo_q[1] ? S_ADD : S_SHIFT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = {hi_q, lo_q};
  assign zero   = (result == '0);

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mcand, mplier;
  logic        busy, done, zero;
  logic [31:0] result;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_f;
  logic        alu_fsel, alu_csel, alu_ucin, alu_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_fsel(alu_fsel),
    .alu_csel(alu_csel), .alu_ucin(alu_ucin), .alu_y(alu_y), .alu_cout(alu_cout)
  );

  // Behavioural model of the shared ALU.
  always_comb begin
    logic [16:0] sum;
    logic        cin;
    alu_y    = '0;
    alu_cout = 1'b0;
    cin      = alu_csel ? 1'b1 : alu_ucin;
    sum      = '0;
    if (alu_fsel) begin
      alu_y = alu_a >> alu_b[3:0];
    end else if (alu_f == 5'b10010) begin
      sum      = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, cin};
      alu_y    = sum[15:0];
      alu_cout = sum[16];
    end
  end

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  // Counts ALU-drive protocol violations seen while waiting.
  int proto_err;
  int fsel_low_busy;

  task automatic check_proto();
    if ($isunknown({alu_a, alu_b, alu_f, alu_fsel, alu_csel, alu_ucin})) proto_err++;
    if (alu_csel !== 1'b0 || alu_ucin !== 1'b0) proto_err++;
    if (alu_f !== 5'b00000 && alu_f !== 5'b10010) proto_err++;
    if (alu_fsel && (alu_f !== 5'b00000 || alu_b !== 16'd1)) proto_err++;
    if (!busy && (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_fsel !== 1'b0)) proto_err++;
    if (busy && !alu_fsel) fsel_low_busy++;
  endtask

  // Drive start at a negedge; the following posedge is cycle 0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
  endtask

  // Already at the negedge of cycle 1 after issue(); count until done.
  task automatic wait_done(output int cyc, output bit timeout);
    cyc = 1; timeout = 0;
    check_proto();
    while (!done) begin
      if (cyc > 100) begin timeout = 1; return; end
      @(negedge clk);
      cyc++;
      check_proto();
    end
  endtask

  task automatic run_check(input string name, input logic [15:0] a, input logic [15:0] b);
    int cyc; bit to;
    logic [31:0] exp_r;
    int exp_c;
    exp_r = 32'(a) * 32'(b);
    exp_c = 17 + popcnt(b);
    proto_err = 0;
    issue(a, b);
    wait_done(cyc, to);
    total++;
    if (to) begin
      bad++; $display("FAIL %s timeout: no done within 100 cycles", name);
    end else begin
      if (cyc !== exp_c) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_c); end
      total++;
      if (result !== exp_r) begin bad++; $display("FAIL %s result: got %h want %h (%h*%h)", name, result, exp_r, a, b); end
      total++;
      if (zero !== (exp_r == 0)) begin bad++; $display("FAIL %s zero: got %b want %b", name, zero, exp_r == 0); end
      // result must be held in the following IDLE cycle and done must drop.
      @(negedge clk);
      total++;
      if (done !== 1'b0 || result !== exp_r) begin
        bad++; $display("FAIL %s hold: done=%b result=%h want done=0 result=%h", name, done, result, exp_r);
      end
    end
    total++;
    if (proto_err != 0) begin bad++; $display("FAIL %s alu_drive: got %0d violations want 0", name, proto_err); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mcand = 16'hAAAA; mplier = 16'h5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, zero} !== 3'b001 || result !== 32'd0) begin
      bad++; $display("FAIL reset_state: busy=%b done=%b zero=%b result=%h want 0 0 1 0", busy, done, zero, result);
    end
    total++;
    if (alu_f !== 5'd0 || alu_fsel !== 1'b0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      bad++; $display("FAIL reset_alu: f=%b fsel=%b a=%h b=%h want all 0", alu_f, alu_fsel, alu_a, alu_b);
    end
  endtask

  task automatic test_basic();
    run_check("basic_3x5", 16'd3, 16'd5);
  endtask

  task automatic test_extreme();
    run_check("extreme_ffff", 16'hFFFF, 16'hFFFF);
    run_check("msb_only", 16'h8000, 16'h8000);
  endtask

  task automatic test_zero_mplier();
    fsel_low_busy = 0;
    run_check("zero_mplier", 16'h1234, 16'h0000);
    total++;
    if (fsel_low_busy != 0) begin
      bad++; $display("FAIL zero_fsel: got %0d busy cycles with fsel=0 want 0", fsel_low_busy);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit to;
    proto_err = 0;
    issue(16'd7, 16'd9);
    cyc = 1; to = 0;
    while (!done && !to) begin
      if (cyc == 5) begin start = 1'b1; mcand = 16'd2; mplier = 16'd2; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
      if (cyc > 100) to = 1;
    end
    start = 1'b0;
    total++;
    if (to || result !== 32'd63 || cyc !== 17 + popcnt(16'd9)) begin
      bad++; $display("FAIL busy_ignore: result=%h cyc=%0d want 0000003f cyc=%0d", result, cyc, 17 + popcnt(16'd9));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    proto_err = 0;
    issue(16'd11, 16'd13);
    wait_done(cyc, to);
    total++;
    if (to || result !== 32'd143) begin
      bad++; $display("FAIL b2b_first: result=%h want 0000008f", result);
    end
    // In the DONE cycle: start the next multiply immediately.
    start = 1'b1; mcand = 16'd2; mplier = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(cyc, to);
    total++;
    if (to || result !== 32'd6 || cyc !== 17 + popcnt(16'd3)) begin
      bad++; $display("FAIL b2b_second: result=%h cyc=%0d want 00000006 cyc=%0d", result, cyc, 17 + popcnt(16'd3));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(16'd100, 16'd200);
    repeat (7) @(negedge clk);   // now in cycle 8
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      bad++; $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b want 0 0 0 1", busy, done, result, zero);
    end
    run_check("after_reset_10x10", 16'd10, 16'd10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) b = 16'h0001;
      if (i == 1) a = 16'h0000;
      run_check($sformatf("random_%0d", i), a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_zero_mplier();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
